// File: rtl/fft_ctrl_seq.sv
// rtl/fft_ctrl_seq.sv - 32-point radix-2 DIF FFT address/control sequencer (option: FFT_BITREV_UNLOAD_EN adds bit-reversed unload)
module fft_ctrl_seq #(
    parameter int BFLY_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic       bfly_valid,
    output logic [4:0] addr_a,
    output logic [4:0] addr_b,
    output logic [3:0] tw_addr,
    output logic [2:0] stage,
    output logic       wr_valid,
    output logic [4:0] wr_addr_a,
    output logic [4:0] wr_addr_b,
    output logic       rd_valid,
    output logic [4:0] rd_addr
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UNLOAD, DONE} state_t;

    // Marks the delay-line slot that is presenting wr_valid this cycle.
    localparam logic [BFLY_LAT-1:0] LAST_SLOT = ~({BFLY_LAT{1'b1}} >> 1);

    state_t              state;
    logic [3:0]          j;
    logic [BFLY_LAT-1:0] vld_pipe;
    logic [4:0]          a_pipe [BFLY_LAT];
    logic [4:0]          b_pipe [BFLY_LAT];

    logic [2:0]          iss_stage;
    logic [3:0]          iss_j;
    logic [4:0]          span;
    logic [4:0]          msk;
    logic [4:0]          jj;
    logic [4:0]          iss_a;
    logic [4:0]          iss_b;
    logic [3:0]          iss_tw;
    logic                drain_clear;

`ifdef FFT_BITREV_UNLOAD_EN
    logic [5:0]          rd_n;
    logic                rd_valid_q;
    logic [4:0]          rd_addr_q;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    assign rd_valid = rd_valid_q;
    assign rd_addr  = rd_addr_q;
`else
    assign rd_valid = 1'b0;
    assign rd_addr  = 5'd0;
`endif

    assign wr_valid  = vld_pipe[BFLY_LAT-1];
    assign wr_addr_a = a_pipe[BFLY_LAT-1];
    assign wr_addr_b = b_pipe[BFLY_LAT-1];

    // Nothing in flight except the entry currently on wr_valid: next stage may issue.
    assign drain_clear = !bfly_valid && ((vld_pipe & ~LAST_SLOT) == '0);

    // Address of the butterfly that would be issued at the coming edge (DIF ordering).
    always_comb begin
        iss_stage = stage;
        iss_j     = j;
        if (state == IDLE) begin
            iss_stage = 3'd0;
            iss_j     = 4'd0;
        end else if (state == DRAIN) begin
            iss_stage = stage + 3'd1;
            iss_j     = 4'd0;
        end
        span   = 5'd16 >> iss_stage;
        msk    = span - 5'd1;
        jj     = {1'b0, iss_j};
        iss_a  = ((jj & ~msk) << 1) | (jj & msk);
        iss_b  = iss_a + span;
        iss_tw = 4'((jj & msk) << iss_stage);
    end

    // Write-back delay line: shifts every cycle, stall does not freeze it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                a_pipe[i] <= 5'd0;
                b_pipe[i] <= 5'd0;
            end
        end else begin
            for (int i = BFLY_LAT - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
            vld_pipe[0] <= bfly_valid;
            a_pipe[0]   <= addr_a;
            b_pipe[0]   <= addr_b;
        end
    end

    // Sequencer FSM with registered outputs: each edge decides what is presented next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            j          <= 4'd0;
            stage      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bfly_valid <= 1'b0;
            addr_a     <= 5'd0;
            addr_b     <= 5'd0;
            tw_addr    <= 4'd0;
`ifdef FFT_BITREV_UNLOAD_EN
            rd_n       <= 6'd0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= 5'd0;
`endif
        end else begin
            done       <= 1'b0;
            bfly_valid <= 1'b0;
`ifdef FFT_BITREV_UNLOAD_EN
            rd_valid_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        stage <= 3'd0;
                        busy  <= 1'b1;
                        j     <= 4'd0;
                        if (!stall) begin
                            bfly_valid <= 1'b1;
                            addr_a     <= iss_a;
                            addr_b     <= iss_b;
                            tw_addr    <= iss_tw;
                            j          <= 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        bfly_valid <= 1'b1;
                        addr_a     <= iss_a;
                        addr_b     <= iss_b;
                        tw_addr    <= iss_tw;
                        j          <= j + 4'd1;
                        if (j == 4'd15) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_clear) begin
                        if (stage == 3'd4) begin
`ifdef FFT_BITREV_UNLOAD_EN
                            state <= UNLOAD;
                            rd_n  <= 6'd0;
                            if (!stall) begin
                                rd_valid_q <= 1'b1;
                                rd_addr_q  <= bitrev5(5'd0);
                                rd_n       <= 6'd1;
                            end
`else
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end else begin
                            state <= ISSUE;
                            stage <= stage + 3'd1;
                            j     <= 4'd0;
                            if (!stall) begin
                                bfly_valid <= 1'b1;
                                addr_a     <= iss_a;
                                addr_b     <= iss_b;
                                tw_addr    <= iss_tw;
                                j          <= 4'd1;
                            end
                        end
                    end
                end
                UNLOAD: begin
`ifdef FFT_BITREV_UNLOAD_EN
                    if (rd_n == 6'd32) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (!stall) begin
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= bitrev5(rd_n[4:0]);
                        rd_n       <= rd_n + 6'd1;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
